// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch unit.
// Owns the architectural PC, issues one instruction-memory read at a time,
// hands the fetched word to decode/execute and waits for the resolved next PC.
//
// Handshake rule for both channels (imem request, instruction to decode):
// a transfer happens on a rising clock edge where valid and ready are both 1.
// Once valid is raised, the payload is held stable and valid stays high until
// that transfer. Valid never depends combinationally on ready.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        wb_valid,
    input  logic [31:0] wb_next_pc,
    output logic [31:0] pc,
    output logic        fetch_err,
    output logic [1:0]  err_cause,
    output logic [31:0] fetch_cnt,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_BOOT = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_EXEC = 3'd4,
        S_ERR  = 3'd5
    } state_e;

    localparam logic [1:0]  CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_TIMEOUT  = 2'b10;
    // Last WAIT cycle index that may still receive a response.
    localparam logic [15:0] WAIT_LAST      = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        err_q, err_d;
    logic [1:0]  cause_q, cause_d;

    // State register and datapath registers; reset forces everything back to boot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            wait_cnt_q  <= '0;
            fetch_cnt_q <= '0;
            err_q       <= 1'b0;
            cause_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            wait_cnt_q  <= wait_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
            err_q       <= err_d;
            cause_q     <= cause_d;
        end
    end

    // Next-state logic; inputs not relevant to the current state are ignored.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        wait_cnt_d  = wait_cnt_q;
        fetch_cnt_d = fetch_cnt_q;
        err_d       = err_q;
        cause_d     = cause_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                // A response in the last allowed cycle beats the timeout.
                if (imem_rsp_valid) begin
                    inst_d    = imem_rsp_data;
                    inst_pc_d = pc_q;
                    state_d   = S_HOLD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    state_d     = S_EXEC;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                end
            end
            S_EXEC: begin
                if (wb_valid) begin
                    if (wb_next_pc[1:0] == 2'b00) begin
                        pc_d    = wb_next_pc;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        cause_d = CAUSE_MISALIGN;
                    end
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Moore outputs taken straight from registers.
    assign imem_req_valid = (state_q == S_REQ);
    assign inst_valid     = (state_q == S_HOLD);
    assign imem_req_addr  = pc_q;
    assign pc             = pc_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_err      = err_q;
    assign err_cause      = cause_q;
    assign fetch_cnt      = fetch_cnt_q;
    assign dbg_state      = state_q;

endmodule
